alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU with an iterative multiply/divide unit and a valid/ready handshake. It replaces the combinational datapath ALU wherever multi-cycle `mul`/`div` and a full-width `hi` result are required. Single-cycle ops complete in 1 cycle; multiply and divide take WIDTH cycles and stall the issuer through `ready_o`.

## Interface
- `WIDTH`, 32, operand/result width; even, ≥ 8
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `valid_i`  in  1  operation request; accepted on an edge with `valid_i && ready_o`
- `ready_o`  out  1  high in IDLE only
- `src1_i`  in  WIDTH  operand 1 (shift amount for sra)
- `src2_i`  in  WIDTH  operand 2
- `ctrl_i`  in  4  opcode
- `valid_o`  out  1  one-cycle pulse: result registers updated this cycle
- `result_o`  out  WIDTH  low result / quotient
- `hi_o`  out  WIDTH  high product / remainder; 0 for single-cycle ops
- `zero_o`  out  1  registered zero flag for the result

## Operation
- Opcodes: 0000 and; 0001 or; 0010 add; 0110 sub; 0101 sub with inverted zero (bne); 0111 sltu; 1000 slt (signed); 1001 sra: `src2 >>> src1[log2(WIDTH)-1:0]`; 1011 lui: `src2 << WIDTH/2`; 1010 mul signed; 1100 mulu; 1101 div signed; 1110 divu; all others produce result 0, hi 0.
- Add/sub wrap modulo 2^WIDTH with no overflow flag.
- `zero_o = (result == 0) XOR (op == 0101)`, computed from the final result.
- mul/mulu produce a 2·WIDTH-bit product: low half to `result_o`, high half to `hi_o`.
- Signed multiply: operate on magnitudes with an unsigned shift-add, one bit per cycle. Negate the 2W product if the operand signs differ.
- div/divu use restoring division, one bit per cycle.
  - Signed: quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Divide by zero: quotient all-ones, remainder = src1. Completes in 1 cycle, no iteration.
  - `-2^(W-1) / -1`: quotient `-2^(W-1)`, remainder 0. This falls out of the magnitude path.
- Operands and opcode are latched at acceptance; input changes during BUSY are ignored.
- FSM:
  - IDLE → BUSY on accepting mul/mulu/div/divu with a nonzero divisor; count loaded with WIDTH-1.
  - BUSY decrements the count each cycle. On the edge where count = 0, results are written, `valid_o` = 1, and the FSM returns to IDLE.
  - All other accepted ops stay in IDLE.
- `valid_i` is ignored while `ready_o` = 0. There is no output backpressure.

## Timing
- Reset values: `ready_o` = 1, `valid_o` = 0, `result_o` = 0, `hi_o` = 0, `zero_o` = 0; FSM in IDLE, count 0.
- Reset asserted mid-operation aborts the operation immediately: no `valid_o` pulse, outputs cleared.
- Single-cycle op (or divide-by-zero) accepted at edge k: results are written and `valid_o` is high after edge k+1, for exactly one cycle.
  - Back-to-back acceptance on every edge is legal, giving 1 result per cycle.
- Multi-cycle op accepted at edge k: `ready_o` falls after edge k. Results are written and `valid_o` pulses after edge k+WIDTH; `ready_o` rises in the same cycle.
  - A new request may be accepted at edge k+WIDTH+1 (k+WIDTH+1 after the pulse cycle).
- `result_o`, `hi_o` and `zero_o` hold their last values until the next `valid_o`.
- `valid_o` is never asserted during BUSY except on the completion cycle.

## Test plan
- Reset: assert `rst_i` asynchronously mid-cycle. Outputs go to their reset values immediately and `ready_o` = 1 after release.
- Single-cycle ops, issued back-to-back (WIDTH = 32):
  - add 0xFFFFFFFF+1 → 0, `zero_o` = 1
  - slt 0xFFFFFFFF,1 → 1
  - sltu same operands → 0
  - sra 4, 0x80000000 → 0xF8000000
  - lui 0x1234 → 0x12340000
  - op 0101 with equal operands → `zero_o` = 0
  - expected: one `valid_o` per cycle
- mul -3 × 7 → `result_o` 0xFFFFFFEB, `hi_o` 0xFFFFFFFF. mulu 0xFFFFFFFF × 2 → `result_o` 0xFFFFFFFE, `hi_o` 1. Expected: `valid_o` exactly 32 cycles after acceptance, `ready_o` low throughout.
- div -7 / 2 → `result_o` 0xFFFFFFFD, `hi_o` 0xFFFFFFFF. divu 100 / 7 → 14, 2. div 0x80000000 / -1 → 0x80000000, 0.
- div 5 / 0 → `result_o` 0xFFFFFFFF, `hi_o` 5, latency 1 cycle.
- Hold `valid_i` high with changing operands during a mul. Required: nothing accepted until `ready_o` rises, mul result unaffected. Then reset 10 cycles into a div: no `valid_o`, outputs 0.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with an iterative shift-add multiplier and restoring divider.
// Single-cycle ops and divide-by-zero take 1 cycle; mul/div take WIDTH cycles with ready_o low.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_LUI  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIV  = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic             neg_q, neg_d, rneg_q, rneg_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic             zero_q, zero_d, valid_q, valid_d;

  logic             accept, in_multi, in_div, in_signed, in_div0, sgn1, sgn2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] s_res, s_hi;
  logic             is_div_op;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [WIDTH-1:0] step_hi, step_lo, fin_res, fin_hi;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    accept    = valid_i && (state_q == S_IDLE);
    in_multi  = ctrl_i inside {OP_MUL, OP_MULU, OP_DIV, OP_DIVU};
    in_div    = (ctrl_i == OP_DIV) || (ctrl_i == OP_DIVU);
    in_signed = (ctrl_i == OP_MUL) || (ctrl_i == OP_DIV);
    in_div0   = in_div && (src2_i == '0);
    sgn1      = in_signed && src1_i[WIDTH-1];
    sgn2      = in_signed && src2_i[WIDTH-1];
    mag1      = sgn1 ? -src1_i : src1_i;
    mag2      = sgn2 ? -src2_i : src2_i;
  end

  // Single-cycle results come from the operands latched at acceptance.
  always_comb begin
    s_res = '0;
    s_hi  = '0;
    case (op_q)
      OP_AND:          s_res = a_q & b_q;
      OP_OR:           s_res = a_q | b_q;
      OP_ADD:          s_res = a_q + b_q;
      OP_SUB, OP_BNE:  s_res = a_q - b_q;
      OP_SLTU:         s_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_SLT:          s_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SRA:          s_res = $signed(b_q) >>> a_q[SHW-1:0];
      OP_LUI:          s_res = b_q << (WIDTH/2);
      OP_DIV, OP_DIVU: begin
        s_res = '1;
        s_hi  = a_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    is_div_op = (op_q == OP_DIV) || (op_q == OP_DIVU);
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, opnd_q};
    if (is_div_op) begin
      if (!rem_diff[WIDTH]) begin
        step_hi = rem_diff[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    if (is_div_op) begin
      fin_res = neg_q  ? -step_lo : step_lo;
      fin_hi  = rneg_q ? -step_hi : step_hi;
    end else begin
      fin_res = prod[WIDTH-1:0];
      fin_hi  = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    pend_d   = 1'b0;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    res_d    = res_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;

    if (pend_q) begin
      res_d   = s_res;
      hi_d    = s_hi;
      zero_d  = (s_res == '0) ^ (op_q == OP_BNE);
      valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = ctrl_i;
          a_d  = src1_i;
          b_d  = src2_i;
          if (in_multi && !in_div0) begin
            state_d  = S_BUSY;
            cnt_d    = SHW'(WIDTH-1);
            acc_hi_d = '0;
            acc_lo_d = mag1;
            opnd_d   = mag2;
            neg_d    = sgn1 ^ sgn2;
            rneg_d   = sgn1;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          res_d   = fin_res;
          hi_d    = fin_hi;
          zero_d  = (fin_res == '0);
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pend_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pend_q   <= pend_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = valid_q;
  assign result_o = res_q;
  assign hi_o     = hi_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, multi-cycle corner sequences and
// randomized ops scored against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  src1_i = '0;
  logic [W-1:0]  src2_i = '0;
  logic [3:0]    ctrl_i = '0;
  logic          valid_o;
  logic [W-1:0]  result_o;
  logic [W-1:0]  hi_o;
  logic          zero_o;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i),
    .valid_o(valid_o), .result_o(result_o), .hi_o(hi_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r, h;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] r, h;
    logic        z;
    int          due;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   bsy_from = 1;
  int   bsy_to = 0;
  exp_t sbq[$];
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op, input logic [31:0] b);
    return (op inside {4'hA, 4'hC, 4'hD, 4'hE}) && !((op == 4'hD || op == 4'hE) && b == 0);
  endfunction

  // Reference model built from plain 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [31:0] h, output logic z);
    longint sa, sb, q;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = a[4:0];
    r = 0;
    h = 0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h5, 4'h6: r = a - b;
      4'h7: r = 32'(a < b);
      4'h8: r = 32'(sa < sb);
      4'h9: r = 32'(sb >>> sh);
      4'hB: r = b << 16;
      4'hA: begin p = 64'(sa * sb); r = p[31:0]; h = p[63:32]; end
      4'hC: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; h = p[63:32]; end
      4'hD: if (b == 0) begin r = '1; h = a; end
            else begin q = sa / sb; r = 32'(q); q = sa % sb; h = 32'(q); end
      4'hE: if (b == 0) begin r = '1; h = a; end
            else begin r = a / b; h = a % b; end
      default: ;
    endcase
    z = (r == 0) ^ (op == 4'h5);
  endtask

  // Present a request starting at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [31:0] h, input logic z);
    exp_t x;
    int guard;
    valid_i = 1'b1;
    ctrl_i  = op;
    src1_i  = a;
    src2_i  = b;
    guard   = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL ready timeout: ready_o=%b, expected 1 within 100 cycles", ready_o);
      valid_i = 1'b0;
      return;
    end
    x.r = r;
    x.h = h;
    x.z = z;
    x.due = cyc + 1 + (is_multi(op, b) ? W : 1);
    if (is_multi(op, b)) begin
      bsy_from = cyc + 1;
      bsy_to   = cyc + W;
    end
    sbq.push_back(x);
    @(negedge clk);
  endtask

  task automatic issue_rand(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r, h;
    logic z;
    model(op, a, b, r, h, z);
    issue(op, a, b, r, h, z);
  endtask

  always @(negedge clk) begin
    if (!rst_i) begin
      chk("ready", {31'b0, ready_o}, {31'b0, !(cyc >= bsy_from && cyc <= bsy_to)});
      if (valid_o) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious valid_o at cycle %0d: result=%h, expected no pulse", cyc, result_o);
        end else begin
          e = sbq.pop_front();
          chk("latency", 32'(cyc), 32'(e.due));
          chk("result", result_o, e.r);
          chk("hi", hi_o, e.h);
          chk("zero", {31'b0, zero_o}, {31'b0, e.z});
        end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing valid_o at cycle %0d: got 0, expected pulse due at %0d", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  localparam int NV = 22;
  vec_t vt[NV];

  task automatic check_reset_state(input string tag);
    chk({tag, "_result"}, result_o, 32'h0);
    chk({tag, "_hi"}, hi_o, 32'h0);
    chk({tag, "_zero"}, {31'b0, zero_o}, 32'h0);
    chk({tag, "_valid"}, {31'b0, valid_o}, 32'h0);
    chk({tag, "_ready"}, {31'b0, ready_o}, 32'h1);
  endtask

  initial begin
    vt[0]  = '{4'h2, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1};
    vt[1]  = '{4'h8, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,        1'b0};
    vt[2]  = '{4'h7, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,        1'b1};
    vt[3]  = '{4'h9, 32'h4,        32'h80000000, 32'hF8000000, 32'h0,        1'b0};
    vt[4]  = '{4'hB, 32'h0,        32'h1234,     32'h12340000, 32'h0,        1'b0};
    vt[5]  = '{4'h5, 32'h5,        32'h5,        32'h0,        32'h0,        1'b0};
    vt[6]  = '{4'h5, 32'h5,        32'h3,        32'h2,        32'h0,        1'b1};
    vt[7]  = '{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        1'b0};
    vt[8]  = '{4'h1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0,        1'b0};
    vt[9]  = '{4'h6, 32'h5,        32'h7,        32'hFFFFFFFE, 32'h0,        1'b0};
    vt[10] = '{4'h3, 32'h1234,     32'h5678,     32'h0,        32'h0,        1'b1};
    vt[11] = '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
    vt[12] = '{4'hA, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    vt[13] = '{4'hC, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'h1,        1'b0};
    vt[14] = '{4'hD, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vt[15] = '{4'hE, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vt[16] = '{4'hD, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0};
    vt[17] = '{4'hD, 32'h5,        32'h0,        32'hFFFFFFFF, 32'h5,        1'b0};
    vt[18] = '{4'hE, 32'h9,        32'h0,        32'hFFFFFFFF, 32'h9,        1'b0};
    vt[19] = '{4'hD, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        1'b0};
    vt[20] = '{4'hA, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
    vt[21] = '{4'h9, 32'h1F,       32'h7FFFFFFF, 32'h0,        32'h0,        1'b1};

    // Asynchronous reset asserted between clock edges.
    #2 rst_i = 1'b1;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1 chk("ready_after_reset", {31'b0, ready_o}, 32'h1);

    for (int i = 0; i < NV; i++)
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].h, vt[i].z);
    valid_i = 1'b0;
    repeat (3) @(negedge clk);

    // Keep valid_i high with changing operands while a mul is in flight.
    issue_rand(4'hA, 32'd12345, 32'hFFFFFD5A);
    for (int g = 0; g < 100 && !ready_o; g++) begin
      ctrl_i = 4'($urandom_range(0, 15));
      src1_i = $urandom;
      src2_i = $urandom;
      @(negedge clk);
    end
    issue_rand(4'h2, 32'h1, 32'h1);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset 10 cycles into a divide: no pulse, outputs cleared.
    chk("pre_reset_result", result_o, 32'h2);
    issue_rand(4'hD, 32'd1000, 32'd3);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_i = 1'b1;
    #1 check_reset_state("midop_reset");
    sbq.delete();
    bsy_to = 0;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_reset_result", result_o, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue_rand(op, a, b);
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        @(negedge clk);
      end
    end
    valid_i = 1'b0;

    for (int g = 0; g < 100 && sbq.size() != 0; g++) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
